// File: rtl/ctrl_unit_pipe_if.sv
// ctrl_unit_pipe_if: instruction-field input handshake, flush, and the registered
// control-bundle output handshake of the decode stage.
// The master side drives the instruction fields; the slave side is the decoder.
interface ctrl_unit_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] ALUCtrl;
  logic       Branch;
  logic       MemtoReg;
  logic       MemWrite;
  logic       ALUSrc;
  logic       ALUPCSrc;
  logic       RegWrite;
  logic       PCJal;
  logic       Illegal;
  logic       mdu_start;
  logic       mdu_busy;

  modport master (
    output in_valid, Opcode, Funct3, Funct7, flush, out_ready,
    input  in_ready, out_valid, ALUCtrl, Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc,
           RegWrite, PCJal, Illegal, mdu_start, mdu_busy
  );

  modport slave (
    input  in_valid, Opcode, Funct3, Funct7, flush, out_ready,
    output in_ready, out_valid, ALUCtrl, Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc,
           RegWrite, PCJal, Illegal, mdu_start, mdu_busy
  );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered RV32IM decode stage with valid/ready on both sides.
// M-extension ops park the latched bundle in StMduWait for MUL_LAT / DIV_LAT cycles
// before presenting it downstream. Defining CTRL_PERF_CNT_EN adds the stall_cycles
// output, a saturating count of MDU-busy and backpressured cycles.
module ctrl_unit_pipe #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ctrl_unit_pipe_if.slave        bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  // Elaboration-time sanity check on the configuration.
  if (BITS < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
    $error("ctrl_unit_pipe: BITS, MUL_LAT and DIV_LAT must all be at least 1");
  end

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

  // ALU control encodings (team ALU table).
  localparam logic [4:0] ALUCTRL_NOP    = 5'd0;
  localparam logic [4:0] ALUCTRL_ADD    = 5'd1;
  localparam logic [4:0] ALUCTRL_SUB    = 5'd2;
  localparam logic [4:0] ALUCTRL_SLL    = 5'd3;
  localparam logic [4:0] ALUCTRL_SLT    = 5'd4;
  localparam logic [4:0] ALUCTRL_SLTU   = 5'd5;
  localparam logic [4:0] ALUCTRL_XOR    = 5'd6;
  localparam logic [4:0] ALUCTRL_SRL    = 5'd7;
  localparam logic [4:0] ALUCTRL_SRA    = 5'd8;
  localparam logic [4:0] ALUCTRL_OR     = 5'd9;
  localparam logic [4:0] ALUCTRL_AND    = 5'd10;
  localparam logic [4:0] ALUCTRL_MUL    = 5'd11;
  localparam logic [4:0] ALUCTRL_MULH   = 5'd12;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'd13;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'd14;
  localparam logic [4:0] ALUCTRL_DIV    = 5'd15;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'd16;
  localparam logic [4:0] ALUCTRL_REM    = 5'd17;
  localparam logic [4:0] ALUCTRL_REMU   = 5'd18;
  localparam logic [4:0] ALUCTRL_BEQ    = 5'd19;
  localparam logic [4:0] ALUCTRL_BNE    = 5'd20;
  localparam logic [4:0] ALUCTRL_BLT    = 5'd21;
  localparam logic [4:0] ALUCTRL_BGE    = 5'd22;
  localparam logic [4:0] ALUCTRL_BLTU   = 5'd23;
  localparam logic [4:0] ALUCTRL_BGEU   = 5'd24;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  typedef struct packed {
    logic [4:0] alu;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       alu_pc_src;
    logic       reg_write;
    logic       pc_jal;
    logic       illegal;
  } bundle_t;

  typedef enum logic [1:0] {StIdle, StHold, StMduWait} state_e;

  // Base integer op shared by R-type and I-calc; alt selects SUB/SRA.
  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  op = ALUCTRL_SLL;
      3'b010:  op = ALUCTRL_SLT;
      3'b011:  op = ALUCTRL_SLTU;
      3'b100:  op = ALUCTRL_XOR;
      3'b101:  op = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  op = ALUCTRL_OR;
      default: op = ALUCTRL_AND;
    endcase
    return op;
  endfunction

  bundle_t          dec;
  logic             dec_m;
  logic             dec_div;
  logic             dec_bad;
  bundle_t          bundle_q, bundle_d;
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             in_ready;
  logic             accept;

  // Decode the presented instruction fields into a control bundle.
  always_comb begin
    dec     = '0;
    dec.alu = ALUCTRL_NOP;
    dec_m   = 1'b0;
    dec_div = 1'b0;
    dec_bad = 1'b0;
    case (bus.Opcode)
      OpReg: begin
        dec.reg_write = 1'b1;
        if (bus.Funct7 == F7Mul) begin
          dec_m   = 1'b1;
          dec_div = bus.Funct3[2];
          case (bus.Funct3)
            3'b000:  dec.alu = ALUCTRL_MUL;
            3'b001:  dec.alu = ALUCTRL_MULH;
            3'b010:  dec.alu = ALUCTRL_MULHSU;
            3'b011:  dec.alu = ALUCTRL_MULHU;
            3'b100:  dec.alu = ALUCTRL_DIV;
            3'b101:  dec.alu = ALUCTRL_DIVU;
            3'b110:  dec.alu = ALUCTRL_REM;
            default: dec.alu = ALUCTRL_REMU;
          endcase
        end else if (bus.Funct7 == F7Base) begin
          dec.alu = base_op(bus.Funct3, 1'b0);
        end else if (bus.Funct7 == F7Alt && (bus.Funct3 == 3'b000 || bus.Funct3 == 3'b101)) begin
          dec.alu = base_op(bus.Funct3, 1'b1);
        end else begin
          dec_bad = 1'b1;
        end
      end
      OpImm: begin
        // Funct7 is immediate data except for the shift-by-immediate forms.
        if ((bus.Funct3 == 3'b001 && bus.Funct7 != F7Base) ||
            (bus.Funct3 == 3'b101 && bus.Funct7 != F7Base && bus.Funct7 != F7Alt)) begin
          dec_bad = 1'b1;
        end
        dec.alu       = base_op(bus.Funct3, bus.Funct3 == 3'b101 && bus.Funct7 == F7Alt);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpLoad: begin
        dec.alu        = ALUCTRL_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpStore: begin
        dec.alu       = ALUCTRL_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OpBranch: begin
        dec.branch = 1'b1;
        case (bus.Funct3)
          3'b000:  dec.alu = ALUCTRL_BEQ;
          3'b001:  dec.alu = ALUCTRL_BNE;
          3'b100:  dec.alu = ALUCTRL_BLT;
          3'b101:  dec.alu = ALUCTRL_BGE;
          3'b110:  dec.alu = ALUCTRL_BLTU;
          3'b111:  dec.alu = ALUCTRL_BGEU;
          default: dec_bad = 1'b1;
        endcase
      end
      OpAuipc: begin
        dec.alu        = ALUCTRL_ADD;
        dec.alu_src    = 1'b1;
        dec.alu_pc_src = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpJal: begin
        dec.alu        = ALUCTRL_ADD;
        dec.branch     = 1'b1;
        dec.pc_jal     = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_pc_src = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpJalr: begin
        dec.alu       = ALUCTRL_ADD;
        dec.branch    = 1'b1;
        dec.pc_jal    = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
    // Illegal instructions still flow downstream, but with every side effect masked.
    if (dec_bad) begin
      dec         = '0;
      dec.alu     = ALUCTRL_NOP;
      dec.illegal = 1'b1;
      dec_m       = 1'b0;
      dec_div     = 1'b0;
    end
  end

  // Upstream ready: open when the output slot is empty or draining, never during flush.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = !bus.flush;
      StHold:  in_ready = bus.out_ready && !bus.flush;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // Next-state and registered-output logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    bundle_d    = bundle_q;
    if (bus.flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else if (accept) begin
      bundle_d = dec;
      if (dec_m) begin
        state_d     = StMduWait;
        cnt_d       = dec_div ? DivLoad : MulLoad;
        start_d     = 1'b1;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        state_d     = StHold;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          out_valid_d = 1'b0;
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
          end
        end
        StMduWait: begin
          if (cnt_q == '0) begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // FSM state, wait counter and the registered control bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      bundle_q       <= '0;
      bundle_q.alu   <= ALUCTRL_NOP;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      bundle_q    <= bundle_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.mdu_start = start_q;
  assign bus.mdu_busy  = busy_q;
  assign bus.ALUCtrl   = bundle_q.alu;
  assign bus.Branch    = bundle_q.branch;
  assign bus.MemtoReg  = bundle_q.mem_to_reg;
  assign bus.MemWrite  = bundle_q.mem_write;
  assign bus.ALUSrc    = bundle_q.alu_src;
  assign bus.ALUPCSrc  = bundle_q.alu_pc_src;
  assign bus.RegWrite  = bundle_q.reg_write;
  assign bus.PCJal     = bundle_q.pc_jal;
  assign bus.Illegal   = bundle_q.illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of MDU-busy or backpressured cycles; only rst clears it.
  always_comb begin
    stall_d = stall_q;
    if ((busy_q || (out_valid_q && !bus.out_ready)) && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: directed and randomized checks of ctrl_unit_pipe against a
// transaction-level model (decode table plus accept-time/latency arithmetic).
// Built with or without CTRL_PERF_CNT_EN; the stall counter is checked when present.
module tb_ctrl_unit_pipe;
  localparam int unsigned MulLat = 3;
  localparam int unsigned DivLat = 4;

  localparam logic [4:0] ALUCTRL_NOP = 5'd0,  ALUCTRL_ADD = 5'd1,  ALUCTRL_SUB = 5'd2;
  localparam logic [4:0] ALUCTRL_SLL = 5'd3,  ALUCTRL_SLT = 5'd4,  ALUCTRL_SLTU = 5'd5;
  localparam logic [4:0] ALUCTRL_XOR = 5'd6,  ALUCTRL_SRL = 5'd7,  ALUCTRL_SRA = 5'd8;
  localparam logic [4:0] ALUCTRL_OR  = 5'd9,  ALUCTRL_AND = 5'd10, ALUCTRL_MUL = 5'd11;
  localparam logic [4:0] ALUCTRL_DIV = 5'd15, ALUCTRL_BEQ = 5'd19;

  typedef struct packed {
    logic [12:0] b;    // {ALUCtrl, Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc, RegWrite, PCJal, Illegal}
    logic        is_m;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ctrl_unit_pipe_if bus_if ();
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  ctrl_unit_pipe #(
    .BITS   (32),
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference decoder written straight from the ISA rules and the ALU table.
  function automatic logic [4:0] ref_base(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'd1: return ALUCTRL_SLL;
      3'd2: return ALUCTRL_SLT;
      3'd3: return ALUCTRL_SLTU;
      3'd4: return ALUCTRL_XOR;
      3'd5: return alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'd6: return ALUCTRL_OR;
      default: return ALUCTRL_AND;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    exp_t e;
    logic [4:0] alu;
    bit br, m2r, mw, asrc, apc, rw, pcj, bad, m;
    alu = ALUCTRL_NOP; {br, m2r, mw, asrc, apc, rw, pcj, bad, m} = '0;
    e = '0;
    if (op == 7'b0110011) begin
      rw = 1;
      if (f7 == 7'b0000001) begin m = 1; alu = ALUCTRL_MUL + 5'(f3); end
      else if (f7 == 7'b0000000) alu = ref_base(f3, 0);
      else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) alu = ref_base(f3, 1);
      else bad = 1;
    end else if (op == 7'b0010011) begin
      asrc = 1; rw = 1;
      alu = ref_base(f3, f3 == 3'd5 && f7 == 7'b0100000);
      if (f3 == 3'd1 && f7 != 7'b0000000) bad = 1;
      if (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1;
    end else if (op == 7'b0000011) begin alu = ALUCTRL_ADD; asrc = 1; m2r = 1; rw = 1;
    end else if (op == 7'b0100011) begin alu = ALUCTRL_ADD; asrc = 1; mw = 1;
    end else if (op == 7'b1100011) begin
      br = 1;
      if (f3 == 3'd2 || f3 == 3'd3) bad = 1;
      else if (f3 < 3'd2) alu = ALUCTRL_BEQ + 5'(f3);
      else alu = ALUCTRL_BEQ + 5'(f3) - 5'd2;
    end else if (op == 7'b0010111) begin alu = ALUCTRL_ADD; asrc = 1; apc = 1; rw = 1;
    end else if (op == 7'b1101111) begin alu = ALUCTRL_ADD; br = 1; pcj = 1; asrc = 1; apc = 1; rw = 1;
    end else if (op == 7'b1100111) begin alu = ALUCTRL_ADD; br = 1; pcj = 1; asrc = 1; rw = 1;
    end else bad = 1;
    if (bad) begin
      e.b = 13'b0_0000_0000_0001;
      return e;
    end
    e.b    = {alu, br, m2r, mw, asrc, apc, rw, pcj, 1'b0};
    e.is_m = m;
    e.lat  = m ? ((f3 >= 3'd4) ? 8'(DivLat) : 8'(MulLat)) : 8'd0;
    return e;
  endfunction

  function automatic logic [12:0] obs_bundle();
    return {bus_if.ALUCtrl, bus_if.Branch, bus_if.MemtoReg, bus_if.MemWrite, bus_if.ALUSrc,
            bus_if.ALUPCSrc, bus_if.RegWrite, bus_if.PCJal, bus_if.Illegal};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs are then sampled 1ns later.
  task automatic drive(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic ordy, input logic fl);
    @(negedge clk);
    bus_if.in_valid  = iv;
    bus_if.Opcode    = op;
    bus_if.Funct3    = f3;
    bus_if.Funct7    = f7;
    bus_if.out_ready = ordy;
    bus_if.flush     = fl;
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 7'd0, 3'd0, 7'd0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.flush = 1'b0; bus_if.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.in_valid = 1'b0; bus_if.flush = 1'b0; bus_if.out_ready = 1'b0;
    bus_if.Opcode = '0; bus_if.Funct3 = '0; bus_if.Funct7 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    n_checks++; if (bus_if.mdu_busy !== 1'b0 || bus_if.mdu_start !== 1'b0) begin n_fail++; $display("FAIL reset_mdu: got busy=%b start=%b want 0/0", bus_if.mdu_busy, bus_if.mdu_start); end
    n_checks++; if (obs_bundle() !== 13'd0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", obs_bundle()); end
`ifdef CTRL_PERF_CNT_EN
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
  endtask

  task automatic test_add();
    exp_t e;
    e = model_decode(7'b0110011, 3'b000, 7'b0000000);
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", bus_if.in_ready); end
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b want 1", bus_if.out_valid); end
    n_checks++; if (obs_bundle() !== e.b) begin n_fail++; $display("FAIL add_bundle: got %h want %h", obs_bundle(), e.b); end
    n_checks++; if (bus_if.ALUCtrl !== ALUCTRL_ADD || bus_if.RegWrite !== 1'b1 || bus_if.ALUSrc !== 1'b0 || bus_if.Illegal !== 1'b0) begin
      n_fail++; $display("FAIL add_fields: got alu=%0d rw=%b src=%b ill=%b want 1/1/0/0", bus_if.ALUCtrl, bus_if.RegWrite, bus_if.ALUSrc, bus_if.Illegal); end
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_div();
    exp_t e;
    e = model_decode(7'b0110011, 3'b100, 7'b0000001);
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0);
    for (int k = 1; k <= int'(DivLat); k++) begin
      // An ADD is offered the whole time; it must not be taken while the divider runs.
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0);
      n_checks++; if (bus_if.mdu_start !== (k == 1)) begin n_fail++; $display("FAIL div_start[%0d]: got %b want %b", k, bus_if.mdu_start, k == 1); end
      n_checks++; if (bus_if.mdu_busy !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL div_wait[%0d]: got busy=%b rdy=%b ov=%b want 1/0/0", k, bus_if.mdu_busy, bus_if.in_ready, bus_if.out_valid); end
    end
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b1 || bus_if.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL div_done: got ov=%b busy=%b want 1/0", bus_if.out_valid, bus_if.mdu_busy); end
    n_checks++; if (bus_if.ALUCtrl !== ALUCTRL_DIV || obs_bundle() !== e.b) begin n_fail++; $display("FAIL div_bundle: got %h want %h", obs_bundle(), e.b); end
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL div_drained: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t ea, ej;
    ea = model_decode(7'b0010011, 3'b000, 7'b0000101);
    ej = model_decode(7'b1101111, 3'b011, 7'b1010101);
    drive(1'b1, 7'b0010011, 3'b000, 7'b0000101, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 7'b1101111, 3'b011, 7'b1010101, 1'b0, 1'b0);
      n_checks++; if (bus_if.out_valid !== 1'b1 || obs_bundle() !== ea.b || bus_if.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_hold[%0d]: got ov=%b bundle=%h rdy=%b want 1/%h/0", k, bus_if.out_valid, obs_bundle(), bus_if.in_ready, ea.b); end
    end
    drive(1'b1, 7'b1101111, 3'b011, 7'b1010101, 1'b1, 1'b0);
    n_checks++; if (bus_if.in_ready !== 1'b1 || obs_bundle() !== ea.b) begin n_fail++; $display("FAIL b2b_release: got rdy=%b bundle=%h want 1/%h", bus_if.in_ready, obs_bundle(), ea.b); end
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b1 || obs_bundle() !== ej.b) begin n_fail++; $display("FAIL b2b_jal: got ov=%b bundle=%h want 1/%h", bus_if.out_valid, obs_bundle(), ej.b); end
    n_checks++; if ({bus_if.PCJal, bus_if.Branch, bus_if.RegWrite, bus_if.ALUPCSrc} !== 4'b1111) begin
      n_fail++; $display("FAIL b2b_jal_fields: got %b want 1111", {bus_if.PCJal, bus_if.Branch, bus_if.RegWrite, bus_if.ALUPCSrc}); end
    idle(1'b1);
  endtask

  task automatic test_flush();
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b1, 1'b0);              // MUL accepted at T
    idle(1'b1);                                                            // T+1
    n_checks++; if (bus_if.mdu_start !== 1'b1 || bus_if.mdu_busy !== 1'b1) begin n_fail++; $display("FAIL flush_mul_start: got start=%b busy=%b want 1/1", bus_if.mdu_start, bus_if.mdu_busy); end
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b1);              // T+2, flush
    n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_t2: got %b want 0", bus_if.in_ready); end
    idle(1'b1);                                                            // T+3
    n_checks++; if (bus_if.in_ready !== 1'b1 || bus_if.mdu_busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_t3: got rdy=%b busy=%b ov=%b want 1/0/0", bus_if.in_ready, bus_if.mdu_busy, bus_if.out_valid); end
    for (int k = 0; k < 5; k++) begin
      idle(1'b1);
      n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_complete[%0d]: got %b want 0", k, bus_if.out_valid); end
    end
    // Flush on the very edge the MUL counter expires: the result must still be dropped.
    drive(1'b1, 7'b0110011, 3'b011, 7'b0000001, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b1, 1'b1);
    n_checks++; if (bus_if.mdu_busy !== 1'b1) begin n_fail++; $display("FAIL flush_expiry_busy: got %b want 1", bus_if.mdu_busy); end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      n_checks++; if (bus_if.out_valid !== 1'b0 || bus_if.mdu_busy !== 1'b0) begin
        n_fail++; $display("FAIL flush_expiry[%0d]: got ov=%b busy=%b want 0/0", k, bus_if.out_valid, bus_if.mdu_busy); end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] op, f7;
    logic [2:0] f3;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op = 7'b0000000; f3 = 3'b000; f7 = 7'b0000000; end
        1: begin op = 7'b1100011; f3 = 3'b010; f7 = 7'b0000000; end
        2: begin op = 7'b1100011; f3 = 3'b011; f7 = 7'b0000000; end
        3: begin op = 7'b0110011; f3 = 3'b001; f7 = 7'b0100000; end
        default: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000010; end
      endcase
      e = model_decode(op, f3, f7);
      drive(1'b1, op, f3, f7, 1'b1, 1'b0);
      idle(1'b1);
      n_checks++; if (bus_if.out_valid !== 1'b1 || obs_bundle() !== e.b) begin
        n_fail++; $display("FAIL illegal_bundle[%0d]: got ov=%b bundle=%h want 1/%h", i, bus_if.out_valid, obs_bundle(), e.b); end
      n_checks++; if (bus_if.Illegal !== 1'b1 || bus_if.ALUCtrl !== ALUCTRL_NOP ||
                      {bus_if.RegWrite, bus_if.MemWrite, bus_if.Branch} !== 3'b000) begin
        n_fail++; $display("FAIL illegal_fields[%0d]: got ill=%b alu=%0d rw/mw/br=%b want 1/0/000", i, bus_if.Illegal, bus_if.ALUCtrl, {bus_if.RegWrite, bus_if.MemWrite, bus_if.Branch}); end
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    exp_t slot, e;
    bit occ, exp_ov, exp_rdy;
    int acc_c, avail_c;
    logic iv, ordy, fl;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] r;
    do_reset();
    occ = 0; acc_c = 0; avail_c = 0; slot = '0;
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 29) == 0);
      r    = $urandom;
      f3   = r[2:0];
      case ($urandom_range(0, 9))
        0: op = 7'b0110011; 1: op = 7'b0110011; 2: op = 7'b0010011; 3: op = 7'b0000011;
        4: op = 7'b0100011; 5: op = 7'b1100011; 6: op = 7'b0010111; 7: op = 7'b1101111;
        8: op = 7'b1100111; default: op = r[14:8];
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000; 1: f7 = 7'b0100000; 2: f7 = 7'b0000001; default: f7 = r[22:16];
      endcase
      drive(iv, op, f3, f7, ordy, fl);
      exp_ov  = occ && c >= avail_c;
      exp_rdy = !fl && (!occ || (exp_ov && ordy));
      n_checks++; if (bus_if.out_valid !== exp_ov) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b want %b", c, bus_if.out_valid, exp_ov); end
      n_checks++; if (bus_if.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b want %b", c, bus_if.in_ready, exp_rdy); end
      n_checks++; if (bus_if.mdu_busy !== (occ && c < avail_c)) begin n_fail++; $display("FAIL rand_busy@%0d: got %b want %b", c, bus_if.mdu_busy, occ && c < avail_c); end
      n_checks++; if (bus_if.mdu_start !== (occ && slot.is_m && c == acc_c + 1)) begin
        n_fail++; $display("FAIL rand_start@%0d: got %b want %b", c, bus_if.mdu_start, occ && slot.is_m && c == acc_c + 1); end
      if (exp_ov) begin
        n_checks++; if (obs_bundle() !== slot.b) begin n_fail++; $display("FAIL rand_bundle@%0d: got %h want %h", c, obs_bundle(), slot.b); end
      end
      if (fl) begin
        occ = 0;
      end else begin
        if (exp_ov && ordy) occ = 0;
        if (iv && exp_rdy) begin
          e = model_decode(op, f3, f7);
          slot = e; occ = 1; acc_c = c;
          avail_c = c + 1 + int'(e.lat);
        end
      end
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_rst_mid_mdu();
    drive(1'b1, 7'b0110011, 3'b101, 7'b0000001, 1'b1, 1'b0);              // DIVU
    idle(1'b1);
    idle(1'b1);
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({bus_if.out_valid, bus_if.mdu_busy, bus_if.mdu_start} !== 3'b000 || obs_bundle() !== 13'd0) begin
      n_fail++; $display("FAIL rst_async: got ov/busy/start=%b bundle=%h want 000/0", {bus_if.out_valid, bus_if.mdu_busy, bus_if.mdu_start}, obs_bundle()); end
    n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b want 1", bus_if.in_ready); end
`ifdef CTRL_PERF_CNT_EN
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_async_stall: got %0d want 0", stall_cycles); end
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0);              // DIV at T
    for (int k = 0; k < int'(DivLat); k++) idle(1'b0);
    idle(1'b0);                                                            // T+5: one backpressure cycle
    n_checks++; if (bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_div_valid: got %b want 1", bus_if.out_valid); end
    idle(1'b1);
    idle(1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_div_drained: got %b want 0", bus_if.out_valid); end
`ifdef CTRL_PERF_CNT_EN
    n_checks++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", stall_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    test_rst_mid_mdu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
